// File: rtl/draw_arbiter_pkg.sv
// Shared constants and state type for the rectangle draw arbiter.
// Widths match the vga_adapter pixel bus and request fields.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int XW       = 8;
  localparam int WW       = 4;
  localparam int HW       = 3;
  localparam int CW       = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_e;

endpackage

// File: rtl/draw_arbiter_if.sv
// Request and pixel-output bundle between requesters,
// the draw arbiter and the vga_adapter.
interface draw_arbiter_if
  import draw_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]    req;
  logic [XW*NUM_REQ-1:0] req_x;
  logic [XW*NUM_REQ-1:0] req_y;
  logic [WW*NUM_REQ-1:0] req_w;
  logic [HW*NUM_REQ-1:0] req_h;
  logic [CW*NUM_REQ-1:0] req_colour;

  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic [XW-1:0]         x;
  logic [XW-1:0]         y;
  logic [CW-1:0]         colour;
  logic                  plot;
  logic                  busy;

  modport master (
    output req, req_x, req_y,
    output req_w, req_h, req_colour,
    input  grant, done, x, y,
    input  colour, plot, busy
  );

  modport slave (
    input  req, req_x, req_y,
    input  req_w, req_h, req_colour,
    output grant, done, x, y,
    output colour, plot, busy
  );

endinterface

// File: rtl/draw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request
// at or after the slot following the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] win_o
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(last_i) + 1 + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter that rasterises one requester's
// rectangle at a time onto the vga_adapter pixel port.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clock,
  input  logic           reset,
  draw_arbiter_if.slave  bus
);

  localparam int IW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [8:0] SW9 = 9'(SCREEN_W);
  localparam logic [8:0] SH9 = 9'(SCREEN_H);

  state_e             state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] win;
  logic [XW-1:0]      x0_q, x0_d;
  logic [XW-1:0]      y0_q, y0_d;
  logic [WW-1:0]      w_q, w_d;
  logic [HW-1:0]      h_q, h_d;
  logic [CW-1:0]      c_q, c_d;
  logic [WW-1:0]      col_q, col_d;
  logic [HW-1:0]      row_q, row_d;
  logic [8:0]         px, py;
  logic               last_px;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req_i  (bus.req),
    .last_i (last_q),
    .win_o  (win)
  );

  // 9-bit sums keep off-screen wrap from landing on-screen
  assign px = {1'b0, x0_q} + 9'(col_q);
  assign py = {1'b0, y0_q} + 9'(row_q);
  assign last_px = (col_q == w_q) && (row_q == h_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      gnt_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      c_q     <= c_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    c_d     = c_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = DRAW;
          gnt_d   = win;
          col_d   = '0;
          row_d   = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
              x0_d   = bus.req_x[i*XW +: XW];
              y0_d   = bus.req_y[i*XW +: XW];
              w_d    = bus.req_w[i*WW +: WW];
              h_d    = bus.req_h[i*HW +: HW];
              c_d    = bus.req_colour[i*CW +: CW];
              last_d = IW'(i);
            end
          end
        end
      end
      DRAW: begin
        if (last_px) begin
          state_d = DONE;
        end else if (col_q == w_q) begin
          col_d = '0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant  = '0;
    bus.done   = '0;
    bus.x      = '0;
    bus.y      = '0;
    bus.colour = '0;
    bus.plot   = 1'b0;
    bus.busy   = (state_q != IDLE);
    if (state_q == DRAW) begin
      bus.grant  = gnt_q;
      bus.x      = px[7:0];
      bus.y      = py[7:0];
      bus.colour = c_q;
      bus.plot   = (px < SW9) && (py < SH9);
    end
    if (state_q == DONE) begin
      bus.done = gnt_q;
    end
  end

endmodule
